// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control unit: state encoding,
// instruction classes, opcode/funct constants, ALU op and PC source codes.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR,
    WB_ALU, WB_MEM, BRANCH, JUMP, ILLEGAL
  } state_t;

  typedef enum logic [3:0] {
    CLS_ADDU, CLS_SUBU, CLS_ORI, CLS_LUI, CLS_LW, CLS_SW, CLS_BEQ, CLS_J, CLS_BAD
  } instr_class_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b01;
  localparam logic [1:0] ALU_LUI = 2'b11;

  localparam logic [1:0] PC_SEQ    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_multicycle_ctrl_decoder.sv
// Combinational opcode/funct classifier; anything unsupported maps to CLS_BAD.
module mips_main_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [5:0]   opcode,
  input  logic [5:0]   funct,
  output instr_class_t instr_class
);

  always_comb begin
    instr_class = CLS_BAD;
    case (opcode)
      OP_RTYPE: begin
        if (funct == FN_ADDU)      instr_class = CLS_ADDU;
        else if (funct == FN_SUBU) instr_class = CLS_SUBU;
      end
      OP_ORI:  instr_class = CLS_ORI;
      OP_LUI:  instr_class = CLS_LUI;
      OP_LW:   instr_class = CLS_LW;
      OP_SW:   instr_class = CLS_SW;
      OP_BEQ:  instr_class = CLS_BEQ;
      OP_J:    instr_class = CLS_J;
      default: instr_class = CLS_BAD;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM. Enables for a state are registered on entry,
// except the FETCH handshake and the beq PC load, which follow their inputs.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter bit HALT_ON_ILLEGAL = 1'b1,
  parameter int CNT_W           = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             alu_zero,
  output logic [1:0]       select_aluPerformance,
  output logic             select_anotherAluSource,
  output logic             ctrl_dataMem_Write,
  output logic             ctrl_dataMem2reg,
  output logic             ir_write,
  output logic             pc_write,
  output logic             aluout_write,
  output logic             reg_write,
  output logic             reg_dst,
  output logic [1:0]       pc_src,
  output logic             illegal_instr,
  output logic [CNT_W-1:0] retired_cnt
);

  state_t       state;
  instr_class_t instr_class;
  logic [5:0]   opcode_reg, funct_reg;
  logic [5:0]   dec_opcode, dec_funct;
  logic [1:0]   alu_op_reg, pc_src_reg;
  logic         alu_src_reg, aluout_write_reg, reg_write_reg, reg_dst_reg;
  logic         mem_write_reg, mem2reg_reg, jump_reg, illegal_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic         fetch_take;

  // The decoder sees the live IR while decoding and the latched copy afterwards.
  assign dec_opcode = (state == DECODE) ? opcode : opcode_reg;
  assign dec_funct  = (state == DECODE) ? funct  : funct_reg;

  mips_main_decoder u_decoder (
    .opcode      (dec_opcode),
    .funct       (dec_funct),
    .instr_class (instr_class)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= FETCH;
      opcode_reg       <= '0;
      funct_reg        <= '0;
      alu_op_reg       <= ALU_ADD;
      alu_src_reg      <= 1'b0;
      aluout_write_reg <= 1'b0;
      reg_write_reg    <= 1'b0;
      reg_dst_reg      <= 1'b0;
      mem_write_reg    <= 1'b0;
      mem2reg_reg      <= 1'b0;
      jump_reg         <= 1'b0;
      pc_src_reg       <= PC_SEQ;
      illegal_reg      <= 1'b0;
      cnt_reg          <= '0;
    end else begin
      alu_op_reg       <= ALU_ADD;
      alu_src_reg      <= 1'b0;
      aluout_write_reg <= 1'b0;
      reg_write_reg    <= 1'b0;
      reg_dst_reg      <= 1'b0;
      mem_write_reg    <= 1'b0;
      mem2reg_reg      <= 1'b0;
      jump_reg         <= 1'b0;
      pc_src_reg       <= PC_SEQ;
      case (state)
        FETCH: if (instr_valid) state <= DECODE;
        DECODE: begin
          opcode_reg <= opcode;
          funct_reg  <= funct;
          case (instr_class)
            CLS_ADDU, CLS_SUBU: begin
              state            <= EXEC_R;
              alu_op_reg       <= (instr_class == CLS_SUBU) ? ALU_SUB : ALU_ADD;
              aluout_write_reg <= 1'b1;
            end
            CLS_ORI, CLS_LUI: begin
              state            <= EXEC_I;
              alu_op_reg       <= (instr_class == CLS_LUI) ? ALU_LUI : ALU_OR;
              alu_src_reg      <= 1'b1;
              aluout_write_reg <= 1'b1;
            end
            CLS_LW, CLS_SW: begin
              state            <= MEM_ADDR;
              alu_src_reg      <= 1'b1;
              aluout_write_reg <= 1'b1;
            end
            CLS_BEQ: begin
              state      <= BRANCH;
              alu_op_reg <= ALU_SUB;
              pc_src_reg <= PC_BRANCH;
            end
            CLS_J: begin
              state      <= JUMP;
              jump_reg   <= 1'b1;
              pc_src_reg <= PC_JUMP;
            end
            default: begin
              state       <= ILLEGAL;
              illegal_reg <= 1'b1;
            end
          endcase
        end
        EXEC_R: begin
          state         <= WB_ALU;
          reg_write_reg <= 1'b1;
          reg_dst_reg   <= 1'b1;
        end
        EXEC_I: begin
          state         <= WB_ALU;
          reg_write_reg <= 1'b1;
        end
        MEM_ADDR: begin
          if (instr_class == CLS_LW) begin
            state       <= MEM_RD;
            mem2reg_reg <= 1'b1;
          end else begin
            state         <= MEM_WR;
            mem_write_reg <= 1'b1;
          end
        end
        MEM_RD: begin
          state         <= WB_MEM;
          mem2reg_reg   <= 1'b1;
          reg_write_reg <= 1'b1;
        end
        WB_ALU, WB_MEM, MEM_WR, BRANCH, JUMP: begin
          state   <= FETCH;
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
        ILLEGAL: if (HALT_ON_ILLEGAL == 1'b0) state <= FETCH;
        default: state <= FETCH;
      endcase
    end
  end

  // rst_n gates the handshake so no enable escapes while reset is held.
  assign fetch_take = (state == FETCH) && instr_valid && rst_n;

  assign select_aluPerformance   = alu_op_reg;
  assign select_anotherAluSource = alu_src_reg;
  assign ctrl_dataMem_Write      = mem_write_reg;
  assign ctrl_dataMem2reg        = mem2reg_reg;
  assign ir_write                = fetch_take;
  assign pc_write                = fetch_take | jump_reg | ((state == BRANCH) & alu_zero);
  assign aluout_write            = aluout_write_reg;
  assign reg_write               = reg_write_reg;
  assign reg_dst                 = reg_dst_reg;
  assign pc_src                  = pc_src_reg;
  assign illegal_instr           = illegal_reg;
  assign retired_cnt             = cnt_reg;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: a halting instance (default) and a
// non-halting instance with a 3-bit counter, both checked against a schedule model.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       instr_valid = 1'b0;
  logic       alu_zero = 1'b0;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;

  logic [1:0] alu [2];
  logic       src [2], mw [2], m2r [2], irw [2], pcw [2], aow [2], rw [2], rd [2], ill [2];
  logic [1:0] pcs [2];
  logic [31:0] cnt_h;
  logic [2:0]  cnt_n;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  mips_multicycle_ctrl dut_h (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .opcode(opcode), .funct(funct),
    .alu_zero(alu_zero), .select_aluPerformance(alu[0]), .select_anotherAluSource(src[0]),
    .ctrl_dataMem_Write(mw[0]), .ctrl_dataMem2reg(m2r[0]), .ir_write(irw[0]),
    .pc_write(pcw[0]), .aluout_write(aow[0]), .reg_write(rw[0]), .reg_dst(rd[0]),
    .pc_src(pcs[0]), .illegal_instr(ill[0]), .retired_cnt(cnt_h)
  );

  mips_multicycle_ctrl #(.HALT_ON_ILLEGAL(1'b0), .CNT_W(3)) dut_n (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .opcode(opcode), .funct(funct),
    .alu_zero(alu_zero), .select_aluPerformance(alu[1]), .select_anotherAluSource(src[1]),
    .ctrl_dataMem_Write(mw[1]), .ctrl_dataMem2reg(m2r[1]), .ir_write(irw[1]),
    .pc_write(pcw[1]), .aluout_write(aow[1]), .reg_write(rw[1]), .reg_dst(rd[1]),
    .pc_src(pcs[1]), .illegal_instr(ill[1]), .retired_cnt(cnt_n)
  );

  // ---------------- model: instruction kind + step since FETCH accept ----------------
  localparam int K_ADDU = 0, K_SUBU = 1, K_ORI = 2, K_LUI = 3, K_LW = 4,
                 K_SW = 5, K_BEQ = 6, K_J = 7, K_BAD = 8;

  bit          m_busy [2] = '{1'b0, 1'b0};
  bit          m_ill  [2] = '{1'b0, 1'b0};
  int          m_kind [2] = '{0, 0};
  int          m_step [2] = '{0, 0};
  int unsigned m_cnt  [2] = '{0, 0};

  function automatic int kind_of(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'h00 && fn == 6'h21) return K_ADDU;
    if (op == 6'h00 && fn == 6'h23) return K_SUBU;
    if (op == 6'h0D) return K_ORI;
    if (op == 6'h0F) return K_LUI;
    if (op == 6'h23) return K_LW;
    if (op == 6'h2B) return K_SW;
    if (op == 6'h04) return K_BEQ;
    if (op == 6'h02) return K_J;
    return K_BAD;
  endfunction

  // Step index of the last cycle: CPI minus one.
  function automatic int last_step(input int k);
    if (k == K_LW) return 4;
    if (k == K_BEQ || k == K_J || k == K_BAD) return 2;
    return 3;
  endfunction

  // Expected {alu, src, mw, m2r, irw, pcw, aow, rw, rd, pc_src, illegal}
  function automatic logic [12:0] exp_vec(input int i);
    logic [1:0] e_alu, e_pcs;
    logic e_src, e_mw, e_m2r, e_irw, e_pcw, e_aow, e_rw, e_rd;
    int k, s;
    {e_alu, e_pcs, e_src, e_mw, e_m2r, e_irw, e_pcw, e_aow, e_rw, e_rd} = '0;
    k = m_kind[i];
    s = m_step[i];
    if (!rst_n) return '0;
    if (!m_busy[i]) begin
      e_irw = instr_valid;
      e_pcw = instr_valid;
    end else if (s == 2) begin
      case (k)
        K_ADDU: e_aow = 1'b1;
        K_SUBU: begin e_alu = 2'b10; e_aow = 1'b1; end
        K_ORI:  begin e_alu = 2'b01; e_src = 1'b1; e_aow = 1'b1; end
        K_LUI:  begin e_alu = 2'b11; e_src = 1'b1; e_aow = 1'b1; end
        K_LW, K_SW: begin e_src = 1'b1; e_aow = 1'b1; end
        K_BEQ:  begin e_alu = 2'b10; e_pcw = alu_zero; e_pcs = 2'b01; end
        K_J:    begin e_pcw = 1'b1; e_pcs = 2'b10; end
        default: ;
      endcase
    end else if (s == 3) begin
      case (k)
        K_ADDU, K_SUBU: begin e_rw = 1'b1; e_rd = 1'b1; end
        K_ORI, K_LUI:   e_rw = 1'b1;
        K_LW:           e_m2r = 1'b1;
        K_SW:           e_mw = 1'b1;
        default: ;
      endcase
    end else if (s == 4 && k == K_LW) begin
      e_m2r = 1'b1;
      e_rw  = 1'b1;
    end
    return {e_alu, e_src, e_mw, e_m2r, e_irw, e_pcw, e_aow, e_rw, e_rd, e_pcs, m_ill[i]};
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_busy[i] <= 1'b0;
        m_cnt[i]  <= 0;
        m_ill[i]  <= 1'b0;
      end else if (!m_busy[i]) begin
        if (instr_valid) begin
          m_busy[i] <= 1'b1;
          m_kind[i] <= kind_of(opcode, funct);
          m_step[i] <= 1;
        end
      end else if (m_step[i] == last_step(m_kind[i])) begin
        // Instance 0 halts on an illegal instruction; instance 1 resumes.
        if (!(m_kind[i] == K_BAD && i == 0)) begin
          m_busy[i] <= 1'b0;
          if (m_kind[i] != K_BAD)
            m_cnt[i] <= (m_cnt[i] + 1) & ((i == 0) ? 32'hFFFF_FFFF : 32'h7);
        end
      end else begin
        m_step[i] <= m_step[i] + 1;
        if (m_kind[i] == K_BAD && m_step[i] == 1) m_ill[i] <= 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        logic [12:0] a;
        logic [31:0] ac;
        a  = {alu[i], src[i], mw[i], m2r[i], irw[i], pcw[i], aow[i], rw[i], rd[i], pcs[i], ill[i]};
        ac = (i == 0) ? cnt_h : {29'b0, cnt_n};
        chk($sformatf("outputs[%0d]", i), {51'b0, a}, {51'b0, exp_vec(i)});
        chk($sformatf("retired_cnt[%0d]", i), {32'b0, ac}, {32'b0, (rst_n ? m_cnt[i] : 32'd0)});
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an instruction in FETCH; returns one cycle later, inside DECODE.
  task automatic issue(input logic [5:0] op, input logic [5:0] fn, input logic z);
    instr_valid = 1'b1;
    opcode = op;
    funct = fn;
    alu_zero = z;
    tick();
    instr_valid = 1'b0;
  endtask

  task automatic run(input logic [5:0] op, input logic [5:0] fn, input int cpi);
    issue(op, fn, 1'b0);
    repeat (cpi - 1) tick();
  endtask

  initial begin
    #2;
    rst_n = 1'b0;
    instr_valid = 1'b1;
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_irw", {63'b0, irw[0]}, 64'd0);
    chk("rst_cnt", {32'b0, cnt_h}, 64'd0);
    rst_n = 1'b1;
    instr_valid = 1'b0;
    tick();

    // addu: cycle-by-cycle pins
    instr_valid = 1'b1; opcode = 6'h00; funct = 6'h21;
    #1 chk("addu_c0_irw", {63'b0, irw[0]}, 64'd1);
    tick();
    instr_valid = 1'b0;
    tick();
    chk("addu_c2_alu", {62'b0, alu[0]}, 64'd0);
    chk("addu_c2_aow", {62'b0, src[0], aow[0]}, 64'b01);
    tick();
    chk("addu_c3_wb", {62'b0, rw[0], rd[0]}, 64'b11);
    tick();
    chk("addu_cnt", {32'b0, cnt_h}, 64'd1);

    run(6'h00, 6'h23, 4);
    run(6'h0D, 6'h00, 4);
    run(6'h0F, 6'h00, 4);

    issue(6'h23, 6'h00, 1'b0);
    tick();
    tick();
    chk("lw_c3_m2r", {62'b0, m2r[0], rw[0]}, 64'b10);
    tick();
    chk("lw_c4_m2r_rw", {62'b0, m2r[0], rw[0]}, 64'b11);
    tick();
    chk("lw_c5_m2r", {63'b0, m2r[0]}, 64'd0);

    issue(6'h2B, 6'h00, 1'b0);
    tick();
    chk("sw_c2_mw", {63'b0, mw[0]}, 64'd0);
    tick();
    chk("sw_c3_mw", {63'b0, mw[0]}, 64'd1);
    tick();
    chk("sw_c4_mw", {63'b0, mw[0]}, 64'd0);

    issue(6'h04, 6'h00, 1'b1);
    tick();
    chk("beq_taken", {61'b0, pcw[0], pcs[0]}, 64'b101);
    tick();
    issue(6'h04, 6'h00, 1'b0);
    tick();
    chk("beq_not_taken", {61'b0, pcw[0], pcs[0]}, 64'b001);
    alu_zero = 1'b1;
    #1 chk("beq_mealy", {63'b0, pcw[0]}, 64'd1);
    alu_zero = 1'b0;
    tick();

    run(6'h02, 6'h00, 3);

    for (int c = 0; c < 5; c++) begin
      chk("idle_irw", {62'b0, irw[0], pcw[0]}, 64'd0);
      tick();
    end
    chk("cnt_nine", {32'b0, cnt_h}, 64'd9);
    chk("cnt_wrap", {61'b0, cnt_n}, 64'd1);

    // unsupported opcode 0x3F
    issue(6'h3F, 6'h00, 1'b0);
    tick();
    chk("ill_set", {62'b0, ill[0], ill[1]}, 64'b11);
    tick();
    chk("ill_cnt", {32'b0, cnt_h}, 64'd9);
    instr_valid = 1'b1; opcode = 6'h00; funct = 6'h21;
    #1 chk("ill_halt_vs_resume", {62'b0, irw[0], irw[1]}, 64'b01);
    tick();
    instr_valid = 1'b0;
    repeat (3) tick();
    chk("ill_resume_cnt", {61'b0, cnt_n}, 64'd2);
    chk("ill_sticky", {62'b0, ill[0], ill[1]}, 64'b11);

    // reset held with instr_valid high
    rst_n = 1'b0;
    instr_valid = 1'b1;
    tick();
    chk("rst2_clear", {61'b0, irw[1], ill[0], ill[1]}, 64'd0);
    rst_n = 1'b1;
    instr_valid = 1'b0;
    tick();

    // reset pulsed while in MEM_WR
    issue(6'h2B, 6'h00, 1'b0);
    tick();
    tick();
    chk("sw_mw_before", {62'b0, mw[0], mw[1]}, 64'b11);
    #2 rst_n = 1'b0;
    #1 chk("sw_async_drop", {62'b0, mw[0], mw[1]}, 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // R-type with unknown funct
    issue(6'h00, 6'h20, 1'b0);
    tick();
    chk("bad_funct_ill", {62'b0, ill[0], ill[1]}, 64'b11);
    tick();
    tick();
    chk("bad_funct_cnt", {29'b0, cnt_n, cnt_h}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
MIPS_MULTICYCLE_CTRL -- requirements
Module: mips_multicycle_ctrl

Interface
REQ-001 SHALL have parameter HALT_ON_ILLEGAL, default 1: 1 = stay in ILLEGAL until reset; 0 = return to FETCH after one cycle.
REQ-002 SHALL have parameter CNT_W, default 32: width of retired-instruction counter.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 instr_valid  input  1  instruction memory holds a valid word this cycle.
REQ-007 opcode  input  6  IR[31:26].
REQ-008 funct  input  6  IR[5:0].
REQ-009 alu_zero  input  1  ALU zero flag (beq compare).
REQ-010 select_aluPerformance  output  2  ALU op: 00 add, 10 sub, 01 ori, 11 lui.
REQ-011 select_anotherAluSource  output  1  0 = register operand, 1 = imm16 operand.
REQ-012 ctrl_dataMem_Write  output  1  data memory write enable.
REQ-013 ctrl_dataMem2reg  output  1  data memory read select (lw).
REQ-014 ir_write, pc_write, aluout_write, reg_write, reg_dst  output  1 each  IR load, PC load, ALUOut load, regfile write, dest select (1 = rd, 0 = rt).
REQ-015 pc_src  output  2  00 PC+4, 01 branch target, 10 jump target.
REQ-016 illegal_instr  output  1  sticky unsupported-opcode flag.
REQ-017 retired_cnt  output  CNT_W  count of completed instructions.

Function
REQ-018 States SHALL be FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH, JUMP, ILLEGAL.
REQ-019 FETCH: if instr_valid=0, hold with all enables 0; if 1, assert ir_write, pc_write, pc_src=00, and go to DECODE.
REQ-020 DECODE SHALL latch opcode/funct internally and dispatch: op 000000 with funct 100001 (addu) or 100011 (subu) -> EXEC_R; 001101 (ori) or 001111 (lui) -> EXEC_I; 100011 (lw) or 101011 (sw) -> MEM_ADDR; 000100 (beq) -> BRANCH; 000010 (j) -> JUMP; anything else, including an unknown funct, -> ILLEGAL.
REQ-021 EXEC_R: ALU op 00 (addu) or 10 (subu), source 0, aluout_write=1 -> WB_ALU with reg_dst=1.
REQ-022 EXEC_I: ALU op 01 (ori) or 11 (lui), source 1, aluout_write=1 -> WB_ALU with reg_dst=0.
REQ-023 WB_ALU: reg_write=1 for one cycle, reg_dst per latched class -> FETCH.
REQ-024 MEM_ADDR: ALU op 00, source 1, aluout_write=1 -> MEM_RD (lw) or MEM_WR (sw).
REQ-025 MEM_RD: ctrl_dataMem2reg=1 -> WB_MEM.
REQ-026 WB_MEM: ctrl_dataMem2reg=1, reg_write=1, reg_dst=0 -> FETCH.
REQ-027 MEM_WR: ctrl_dataMem_Write=1 for exactly one cycle -> FETCH.
REQ-028 BRANCH: ALU op 10, source 0; pc_write=alu_zero (the only Mealy output) and pc_src=01 -> FETCH.
REQ-029 JUMP: pc_write=1, pc_src=10 -> FETCH.
REQ-030 ILLEGAL: set illegal_instr, which clears only on reset; retired_cnt SHALL NOT increment; next state per HALT_ON_ILLEGAL.
REQ-031 Outputs not named for a state SHALL be 0; select_* SHALL be 00/0 when unused.
REQ-032 retired_cnt SHALL increment by 1 on each transition into FETCH from WB_ALU, WB_MEM, MEM_WR, BRANCH or JUMP, and SHALL wrap from all-ones to 0.
REQ-033 Cycles per instruction from FETCH accept SHALL be: R/I-type 4, lw 5, sw 4, beq 3, j 3.

Reset
REQ-034 While rst_n=0: state=FETCH, every output 0, retired_cnt=0, illegal_instr=0, latched opcode/funct=0.
REQ-035 Reset asserted mid-instruction (e.g. in MEM_WR) SHALL deassert all enables immediately, without waiting for a clock edge.
REQ-036 The first FETCH SHALL be the first rising edge after rst_n rises.

Structure
REQ-037 Shared package mips_ctrl_pkg SHALL hold the state encoding, opcode/funct constants, ALU op codes and pc_src codes.
REQ-038 Opcode/funct classification SHALL be a combinational sub-module, mips_main_decoder, instantiated once.

Verification
REQ-039 Reset: hold rst_n=0 for 3 cycles -> all outputs 0, retired_cnt=0; release -> FETCH.
REQ-040 addu (op 0, funct 0x21) with instr_valid=1 -> ir_write at cycle 0, ALU 00/0 at cycle 2, reg_write with reg_dst=1 at cycle 3, retired_cnt=1.
REQ-041 lw (0x23) -> ctrl_dataMem2reg high in cycles 3-4, reg_write at cycle 4; sw (0x2B) -> ctrl_dataMem_Write high only in cycle 3.
REQ-042 beq (0x04) with alu_zero=1 -> pc_write=1, pc_src=01 at cycle 2; with alu_zero=0 -> pc_write=0.
REQ-043 Opcode 0x3F -> illegal_instr=1 and retired_cnt unchanged; HALT_ON_ILLEGAL=1 stays stuck, HALT_ON_ILLEGAL=0 returns to FETCH.
REQ-044 instr_valid=0 for 5 cycles -> no enables; rst_n pulsed during MEM_WR -> ctrl_dataMem_Write drops combinationally.
